// File: rtl/harness_run_monitor.sv
// Run watchdog: turns cycle budget, stall limit and DUT pass/fail
// indications into a single verdict delivered over valid/ready.
// Ports:
//   clock, reset_n       : clock, async active-low reset
//   max_cycles           : cycle budget (0 = no timeout)
//   stall_limit          : cycles without progress (0 = no stall check)
//   progress/success/fail: DUT status, sampled only while running
//   report_valid/ready   : verdict handshake
//   report_code          : 0 none, 1 pass, 2 fail, 3 timeout, 4 stall
//   cycle_count, busy    : elapsed run cycles, high while running
module harness_run_monitor #(
    parameter int WIDTH       = 32,
    parameter int STALL_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       max_cycles,
    input  logic [STALL_WIDTH-1:0] stall_limit,
    input  logic                   progress,
    input  logic                   success,
    input  logic                   fail,
    output logic                   report_valid,
    input  logic                   report_ready,
    output logic [2:0]             report_code,
    output logic [WIDTH-1:0]       cycle_count,
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REPORT = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_PASS    = 3'd1;
    localparam logic [2:0] CODE_FAIL    = 3'd2;
    localparam logic [2:0] CODE_TIMEOUT = 3'd3;
    localparam logic [2:0] CODE_STALL   = 3'd4;

    localparam logic [WIDTH-1:0]       CYC_ONE   = 1;
    localparam logic [STALL_WIDTH-1:0] STALL_ONE = 1;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       cycle_q, cycle_d;
    logic [STALL_WIDTH-1:0] stall_q, stall_d;
    logic [2:0]             code_q, code_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic                   timeout_hit;
    logic                   stall_hit;
    logic [2:0]             verdict;

    // Checks look at the registered counters, so a budget of M is
    // seen as exhausted in the cycle after the M-th edge.
    always_comb begin
        timeout_hit = (max_cycles != '0) && (cycle_q == max_cycles);
        stall_hit   = (stall_limit != '0) && (stall_q == stall_limit)
                      && !progress;
        verdict     = CODE_NONE;
        if (fail) begin
            verdict = CODE_FAIL;
        end else if (success) begin
            verdict = CODE_PASS;
        end else if (timeout_hit) begin
            verdict = CODE_TIMEOUT;
        end else if (stall_hit) begin
            verdict = CODE_STALL;
        end
    end

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        stall_d = stall_q;
        code_d  = code_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            ST_RUN: begin
                if (verdict != CODE_NONE) begin
                    // Counters freeze on the deciding edge.
                    state_d = ST_REPORT;
                    code_d  = verdict;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    if (!(&cycle_q)) begin
                        cycle_d = cycle_q + CYC_ONE;
                    end
                    if (progress) begin
                        stall_d = '0;
                    end else if (!(&stall_q)) begin
                        stall_d = stall_q + STALL_ONE;
                    end
                end
            end
            ST_REPORT: begin
                if (report_ready) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_DONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cycle_q <= '0;
            stall_q <= '0;
            code_q  <= CODE_NONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign report_valid = valid_q;
    assign report_code  = code_q;
    assign cycle_count  = cycle_q;
    assign busy         = busy_q;

endmodule
